// File: rtl/mandelbrot_pixel_sched.sv
// Mandelbrot pixel scheduler: walks the frame's c-plane grid, issues pixels to an
// iteration core under a credit limit, and streams the in-order escape counts out of a small FIFO.
module mandelbrot_pixel_sched #(
   parameter int H_RES      = 640,
   parameter int V_RES      = 480,
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] x0,
   input  logic [31:0] y0,
   input  logic [31:0] step,
   output logic        busy,
   output logic        done,
   output logic [31:0] core_cr,
   output logic [31:0] core_ci,
   output logic        core_valid,
   input  logic        core_ready,
   input  logic [7:0]  core_iter,
   input  logic        core_done,
   output logic [7:0]  pix_data,
   output logic        pix_valid,
   input  logic        pix_ready,
   output logic        pix_sof,
   output logic        pix_eol
);

   localparam int XW = $clog2(H_RES);
   localparam int YW = $clog2(V_RES);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t        state_q, state_d;
   logic [31:0]   x0_q, x0_d, step_q, step_d, cr_q, cr_d, ci_q, ci_d;
   logic [XW-1:0] xcnt_q, xcnt_d, ox_q, ox_d;
   logic [YW-1:0] ycnt_q, ycnt_d, oy_q, oy_d;
   logic [CW-1:0] inflight_q, inflight_d, count_q, count_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [7:0]    mem_q [FIFO_DEPTH];
   logic [7:0]    mem_d [FIFO_DEPTH];
   logic          core_valid_q, core_valid_d, pix_valid_q, pix_valid_d;
   logic          pix_sof_q, pix_sof_d, pix_eol_q, pix_eol_d;
   logic          busy_q, busy_d, done_q, done_d;
   logic [7:0]    pix_data_q, pix_data_d;

   logic issue_s, push_s, pop_s, last_issue_s, last_pop_s;
   logic [CW:0] occupied_s;

   // Handshake qualifiers; results arriving outside an active frame are stale and dropped.
   always_comb begin
      issue_s      = (state_q == ST_RUN) && core_valid_q && core_ready;
      push_s       = core_done && ((state_q == ST_RUN) || (state_q == ST_DRAIN));
      pop_s        = pix_valid_q && pix_ready;
      last_issue_s = issue_s && (xcnt_q == XW'(H_RES - 1)) && (ycnt_q == YW'(V_RES - 1));
      last_pop_s   = pop_s && (ox_q == XW'(H_RES - 1)) && (oy_q == YW'(V_RES - 1));
   end

   // Frame FSM plus issue-address generator.
   always_comb begin
      state_d = state_q;
      x0_d    = x0_q;
      step_d  = step_q;
      cr_d    = cr_q;
      ci_d    = ci_q;
      xcnt_d  = xcnt_q;
      ycnt_d  = ycnt_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_RUN;
               x0_d    = x0;
               step_d  = step;
               cr_d    = x0;
               ci_d    = y0;
               xcnt_d  = XW'(0);
               ycnt_d  = YW'(0);
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (last_issue_s) begin
               state_d = ST_DRAIN;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_DRAIN: begin
            if (last_pop_s) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_DRAIN;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      if (issue_s) begin
         if (xcnt_q == XW'(H_RES - 1)) begin
            xcnt_d = XW'(0);
            cr_d   = x0_q;
            ci_d   = ci_q + step_q;
            if (ycnt_q == YW'(V_RES - 1)) begin
               ycnt_d = YW'(0);
            end else begin
               ycnt_d = ycnt_q + YW'(1);
            end
         end else begin
            xcnt_d = xcnt_q + XW'(1);
            cr_d   = cr_q + step_q;
         end
      end else begin
         xcnt_d = xcnt_q;
      end
   end

   // Credit bookkeeping, result FIFO and output raster position.
   always_comb begin
      mem_d = mem_q;
      case ({issue_s, push_s})
         2'b10:   inflight_d = inflight_q + CW'(1);
         2'b01:   inflight_d = inflight_q - CW'(1);
         default: inflight_d = inflight_q;
      endcase
      case ({push_s, pop_s})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      if (push_s) begin
         mem_d[wr_ptr_q] = core_iter;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
         if (ox_q == XW'(H_RES - 1)) begin
            ox_d = XW'(0);
            if (oy_q == YW'(V_RES - 1)) begin
               oy_d = YW'(0);
            end else begin
               oy_d = oy_q + YW'(1);
            end
         end else begin
            ox_d = ox_q + XW'(1);
            oy_d = oy_q;
         end
      end else begin
         rd_ptr_d = rd_ptr_q;
         ox_d     = ox_q;
         oy_d     = oy_q;
      end
   end

   // Registered outputs, computed from next state so credit is exact on every cycle.
   always_comb begin
      occupied_s   = (CW + 1)'(count_d) + (CW + 1)'(inflight_d);
      core_valid_d = (state_d == ST_RUN) && (occupied_s < (CW + 1)'(FIFO_DEPTH));
      busy_d       = (state_d != ST_IDLE);
      done_d       = (state_d == ST_DONE);
      pix_valid_d  = (count_d != CW'(0));
      pix_data_d   = mem_d[rd_ptr_d];
      pix_sof_d    = pix_valid_d && (ox_d == XW'(0)) && (oy_d == YW'(0));
      pix_eol_d    = pix_valid_d && (ox_d == XW'(H_RES - 1));
   end

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         x0_q         <= 32'd0;
         step_q       <= 32'd0;
         cr_q         <= 32'd0;
         ci_q         <= 32'd0;
         xcnt_q       <= XW'(0);
         ycnt_q       <= YW'(0);
         ox_q         <= XW'(0);
         oy_q         <= YW'(0);
         inflight_q   <= CW'(0);
         count_q      <= CW'(0);
         rd_ptr_q     <= AW'(0);
         wr_ptr_q     <= AW'(0);
         mem_q        <= '{default: 8'd0};
         core_valid_q <= 1'b0;
         pix_valid_q  <= 1'b0;
         pix_data_q   <= 8'd0;
         pix_sof_q    <= 1'b0;
         pix_eol_q    <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         x0_q         <= x0_d;
         step_q       <= step_d;
         cr_q         <= cr_d;
         ci_q         <= ci_d;
         xcnt_q       <= xcnt_d;
         ycnt_q       <= ycnt_d;
         ox_q         <= ox_d;
         oy_q         <= oy_d;
         inflight_q   <= inflight_d;
         count_q      <= count_d;
         rd_ptr_q     <= rd_ptr_d;
         wr_ptr_q     <= wr_ptr_d;
         mem_q        <= mem_d;
         core_valid_q <= core_valid_d;
         pix_valid_q  <= pix_valid_d;
         pix_data_q   <= pix_data_d;
         pix_sof_q    <= pix_sof_d;
         pix_eol_q    <= pix_eol_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

   assign core_cr    = cr_q;
   assign core_ci    = ci_q;
   assign core_valid = core_valid_q;
   assign pix_data   = pix_data_q;
   assign pix_valid  = pix_valid_q;
   assign pix_sof    = pix_sof_q;
   assign pix_eol    = pix_eol_q;
   assign busy       = busy_q;
   assign done       = done_q;

endmodule

// File: tb/tb_mandelbrot_pixel_sched.sv
// Directed bench for mandelbrot_pixel_sched on a 4x2 frame with a 3-cycle behavioural core.
module tb_mandelbrot_pixel_sched;

   localparam int H = 4;
   localparam int V = 2;
   localparam int D = 4;
   localparam int N = H * V;

   logic        clk = 1'b0;
   logic        reset, start, core_ready, core_done, pix_ready;
   logic [31:0] x0, y0, step;
   logic [7:0]  core_iter;
   logic        busy, done, core_valid, pix_valid, pix_sof, pix_eol;
   logic [31:0] core_cr, core_ci;
   logic [7:0]  pix_data;

   mandelbrot_pixel_sched #(.H_RES(H), .V_RES(V), .FIFO_DEPTH(D)) dut (
      .clk(clk), .reset(reset), .start(start), .x0(x0), .y0(y0), .step(step),
      .busy(busy), .done(done), .core_cr(core_cr), .core_ci(core_ci),
      .core_valid(core_valid), .core_ready(core_ready), .core_iter(core_iter),
      .core_done(core_done), .pix_data(pix_data), .pix_valid(pix_valid),
      .pix_ready(pix_ready), .pix_sof(pix_sof), .pix_eol(pix_eol)
   );

   always #5 clk = ~clk;

   int          n_tests = 0;
   int          n_fail  = 0;
   int          iss_cnt, out_cnt, done_cnt, done0, stale_n, cyc;
   int          first_iss_cyc, first_out_cyc;
   bit          rand_mode;
   logic [31:0] m_x0, m_y0, m_step;
   logic [31:0] cr_log [16];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Behavioural core (3-cycle latency, returns the in-frame issue index) plus issue/output monitors.
   initial begin : core_model
      logic       pv [3];
      logic [7:0] pd [3];
      logic       iss, stall_prev;
      logic [7:0] iss_id;
      logic [31:0] hold_cr, hold_ci, k;
      pv = '{default: 1'b0};
      pd = '{default: 8'd0};
      stall_prev = 1'b0;
      hold_cr = 32'd0;
      hold_ci = 32'd0;
      iss_id = 8'd0;
      core_done = 1'b0;
      core_iter = 8'd0;
      core_ready = 1'b1;
      forever begin
         @(negedge clk);
         iss = !reset && core_valid && core_ready;
         if (!reset && stall_prev && core_valid) begin
            chk("stall_hold_cr", core_cr, hold_cr);
            chk("stall_hold_ci", core_ci, hold_ci);
         end
         stall_prev = !reset && core_valid && !core_ready;
         hold_cr = core_cr;
         hold_ci = core_ci;
         if (iss) begin
            k = 32'(iss_cnt % H);
            chk("issue_cr", core_cr, m_x0 + m_step * k);
            k = 32'(iss_cnt / H);
            chk("issue_ci", core_ci, m_y0 + m_step * k);
            if (iss_cnt < 16) cr_log[iss_cnt] = core_cr;
            if (iss_cnt == 0) first_iss_cyc = cyc;
            iss_id = 8'(iss_cnt);
            iss_cnt++;
         end
         if (!reset && pix_valid && out_cnt == 0 && first_out_cyc < 0) first_out_cyc = cyc;
         if (!reset && pix_valid && pix_ready) begin
            chk("pix_data", 32'(pix_data), 32'(out_cnt % 256));
            chk("pix_sof", 32'(pix_sof), 32'(out_cnt == 0));
            chk("pix_eol", 32'(pix_eol), 32'((out_cnt % H) == H - 1));
            out_cnt++;
         end
         if (done) done_cnt++;
         @(posedge clk);
         #1;
         if (reset) begin
            pv = '{default: 1'b0};
         end else begin
            pv[2] = pv[1]; pd[2] = pd[1];
            pv[1] = pv[0]; pd[1] = pd[0];
            pv[0] = iss;   pd[0] = iss_id;
         end
         if (stale_n > 0) begin
            core_done = 1'b1;
            core_iter = 8'hEE;
            stale_n--;
         end else begin
            core_done = pv[2];
            core_iter = pd[2];
         end
         core_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   task automatic do_start(input logic [31:0] sx, input logic [31:0] sy, input logic [31:0] ss);
      @(posedge clk);
      #1;
      start = 1'b1; x0 = sx; y0 = sy; step = ss;
      m_x0 = sx; m_y0 = sy; m_step = ss;
      iss_cnt = 0; out_cnt = 0; done0 = done_cnt;
      first_iss_cyc = -1; first_out_cyc = -1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input bit rand_pr);
      int b = 0;
      while (done_cnt == done0 && b < 400) begin
         @(posedge clk);
         #1;
         if (rand_pr) pix_ready = 1'($urandom_range(0, 1));
         b++;
      end
      pix_ready = 1'b1;
      chk("done_seen", 32'(done_cnt != done0), 32'd1);
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("n_issue", 32'(iss_cnt), 32'(N));
      chk("n_out", 32'(out_cnt), 32'(N));
      chk("n_done", 32'(done_cnt - done0), 32'd1);
      chk("idle_busy", 32'(busy), 32'd0);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; x0 = 32'd0; y0 = 32'd0; step = 32'd0;
      pix_ready = 1'b1; rand_mode = 1'b0; stale_n = 0; cyc = 0;
      iss_cnt = 0; out_cnt = 0; done_cnt = 0; done0 = 0;
      m_x0 = 32'd0; m_y0 = 32'd0; m_step = 32'd0;
      first_iss_cyc = -1; first_out_cyc = -1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_core_valid", 32'(core_valid), 32'd0);
      chk("rst_pix_valid", 32'(pix_valid), 32'd0);
      chk("rst_pix_sof", 32'(pix_sof), 32'd0);
      chk("rst_pix_eol", 32'(pix_eol), 32'd0);
      chk("rst_core_cr", core_cr, 32'd0);
      chk("rst_core_ci", core_ci, 32'd0);
      chk("rst_pix_data", 32'(pix_data), 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;

      // Basic frame: grid order, sof/eol, single done, latency of core + 1.
      do_start(32'h0000_0000, 32'hFFFF_0000, 32'h0000_4000);
      @(negedge clk);
      chk("run_busy", 32'(busy), 32'd1);
      wait_done(1'b0);
      chk("a_cr3", cr_log[3], 32'h0000_C000);
      chk("a_cr4", cr_log[4], 32'h0000_0000);
      chk("latency", 32'(first_out_cyc - first_iss_cyc), 32'd4);

      // Real-part wrap past the positive limit.
      do_start(32'h7FFF_F000, 32'h0000_0000, 32'h0000_2000);
      wait_done(1'b0);
      chk("wrap_cr1", cr_log[1], 32'h8000_1000);

      // Output back-pressure: credit caps issues at the FIFO depth.
      pix_ready = 1'b0;
      do_start(32'h0000_0000, 32'hFFFF_0000, 32'h0000_4000);
      repeat (20) @(posedge clk);
      @(negedge clk);
      chk("bp_issues", 32'(iss_cnt), 32'(D));
      chk("bp_core_valid", 32'(core_valid), 32'd0);
      chk("bp_pix_valid", 32'(pix_valid), 32'd1);
      wait_done(1'b1);

      // Random core stalls and output stalls; a start while busy must be ignored.
      rand_mode = 1'b1;
      do_start(32'h0000_0000, 32'hFFFF_0000, 32'h0000_4000);
      @(posedge clk);
      #1;
      start = 1'b1; x0 = 32'h1234_5678; y0 = 32'h0BAD_0000; step = 32'h0000_0100;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done(1'b1);
      rand_mode = 1'b0;

      // Reset mid-frame followed by stale core results.
      do_start(32'h0000_0000, 32'hFFFF_0000, 32'h0000_4000);
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      stale_n = 2;
      done0 = done_cnt;
      repeat (6) @(posedge clk);
      @(negedge clk);
      chk("post_rst_busy", 32'(busy), 32'd0);
      chk("post_rst_core_valid", 32'(core_valid), 32'd0);
      chk("post_rst_pix_valid", 32'(pix_valid), 32'd0);
      chk("post_rst_pix_data", 32'(pix_data), 32'd0);
      chk("post_rst_no_done", 32'(done_cnt - done0), 32'd0);
      do_start(32'h0000_0000, 32'hFFFF_0000, 32'h0000_4000);
      wait_done(1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
